// File: rtl/master_addr_fifo_arbiter_if.sv
// -----------------------------------------------------------------------------
// master_addr_fifo_arbiter_if
// Bundles the two address-FIFO read ports and the single valid/ready output
// channel used by master_addr_fifo_arbiter.
//   ch0_*   : write-address FIFO read port (rd_en out, rd_data/rd_empty in)
//   ch1_*   : read-address FIFO read port  (rd_en out, rd_data/rd_empty in)
//   out_*   : scheduled entry toward the AXI address issue logic
// modport master : the arbiter side
// modport slave  : the FIFOs plus the downstream consumer
// -----------------------------------------------------------------------------
interface master_addr_fifo_arbiter_if #(
  parameter int DATA_WIDTH = 44
);
  logic                  ch0_rd_en;
  logic [DATA_WIDTH-1:0] ch0_rd_data;
  logic                  ch0_rd_empty;
  logic                  ch1_rd_en;
  logic [DATA_WIDTH-1:0] ch1_rd_data;
  logic                  ch1_rd_empty;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_src;

  modport master (
    output ch0_rd_en,
    input  ch0_rd_data,
    input  ch0_rd_empty,
    output ch1_rd_en,
    input  ch1_rd_data,
    input  ch1_rd_empty,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_src
  );

  modport slave (
    input  ch0_rd_en,
    output ch0_rd_data,
    output ch0_rd_empty,
    input  ch1_rd_en,
    output ch1_rd_data,
    output ch1_rd_empty,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_src
  );
endinterface

// File: rtl/master_addr_fifo_arbiter.sv
// -----------------------------------------------------------------------------
// master_addr_fifo_arbiter
// Read-side scheduler for the AXI4 master's write-address (ch0) and
// read-address (ch1) FIFOs. Pops one entry at a time from a non-empty FIFO,
// round-robin on ties, and presents it on a valid/ready channel tagged with
// its source channel.
// Ports:
//   i_rd_clk     : read clock shared with both FIFO read ports
//   i_rd_rst     : asynchronous active-high reset
//   i_arb_en     : 1 = new pops allowed, 0 = finish in-flight entry then idle
//   bus          : FIFO read ports and output channel (master modport)
//   o_busy       : 1 whenever the scheduler is not idle
//   o_issue_cnt  : number of completed output handshakes (wraps)
// -----------------------------------------------------------------------------
module master_addr_fifo_arbiter #(
  parameter int DATA_WIDTH = 44,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 i_rd_clk,
  input  logic                 i_rd_rst,
  input  logic                 i_arb_en,
  master_addr_fifo_arbiter_if.master bus,
  output logic                 o_busy,
  output logic [CNT_WIDTH-1:0] o_issue_cnt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_CAPT  = 2'd2;
  localparam logic [1:0] ST_VALID = 2'd3;

  logic [1:0]            r_state;
  logic                  r_grant;
  logic                  r_last_grant;
  logic                  r_out_valid;
  logic                  r_out_src;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [CNT_WIDTH-1:0]  r_issue_cnt;

  logic [1:0]            w_empty;
  logic [DATA_WIDTH-1:0] w_rd_data [2];
  logic [1:0]            w_rd_en;
  logic                  w_any_ready;
  logic                  w_handshake;
  logic                  w_decide;
  logic                  w_pick;

  assign w_empty      = {bus.ch1_rd_empty, bus.ch0_rd_empty};
  assign w_rd_data[0] = bus.ch0_rd_data;
  assign w_rd_data[1] = bus.ch1_rd_data;

  assign w_any_ready = ~(&w_empty);
  // out_valid is always set while in VALID, so the state alone qualifies it.
  assign w_handshake = (r_state == ST_VALID) && bus.out_ready;
  // Decision points: idle, or the handshake edge of the current entry.
  assign w_decide    = ((r_state == ST_IDLE) || w_handshake) && i_arb_en && w_any_ready;

  // Both ready: alternate away from the last grant. One ready: take it.
  always_comb begin
    w_pick = 1'b0;
    if (!w_empty[0] && !w_empty[1]) begin
      w_pick = ~r_last_grant;
    end else begin
      w_pick = w_empty[0];
    end
  end

  // Pop strobes come straight from registered state so the FIFO sees a clean
  // single-cycle pulse during READ only.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd_en
      assign w_rd_en[gi] = (r_state == ST_READ) && (r_grant == 1'(gi));
    end
  endgenerate

  assign bus.ch0_rd_en = w_rd_en[0];
  assign bus.ch1_rd_en = w_rd_en[1];
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_src   = r_out_src;
  assign o_busy        = (r_state != ST_IDLE);
  assign o_issue_cnt   = r_issue_cnt;

  always_ff @(posedge i_rd_clk or posedge i_rd_rst) begin
    if (i_rd_rst) begin
      r_state      <= ST_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_out_valid  <= 1'b0;
      r_out_src    <= 1'b0;
      r_out_data   <= '0;
      r_issue_cnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_decide) begin
            r_grant      <= w_pick;
            r_last_grant <= w_pick;
            r_state      <= ST_READ;
          end
        end
        ST_READ: begin
          r_state <= ST_CAPT;
        end
        ST_CAPT: begin
          // FIFO read data is valid this cycle, one cycle after the pop.
          r_out_data  <= w_rd_data[r_grant];
          r_out_src   <= r_grant;
          r_out_valid <= 1'b1;
          r_state     <= ST_VALID;
        end
        ST_VALID: begin
          if (w_handshake) begin
            r_issue_cnt <= r_issue_cnt + 1'b1;
            r_out_valid <= 1'b0;
            if (w_decide) begin
              r_grant      <= w_pick;
              r_last_grant <= w_pick;
              r_state      <= ST_READ;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_master_addr_fifo_arbiter.sv
module tb_master_addr_fifo_arbiter;
  localparam int DW = 44;
  localparam int CW = 16;

  logic          rd_clk = 1'b0;
  logic          rd_rst = 1'b1;
  logic          arb_en = 1'b0;
  logic          busy;
  logic [CW-1:0] issue_cnt;

  master_addr_fifo_arbiter_if #(.DATA_WIDTH(DW)) bus ();

  master_addr_fifo_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .i_rd_clk    (rd_clk),
    .i_rd_rst    (rd_rst),
    .i_arb_en    (arb_en),
    .bus         (bus),
    .o_busy      (busy),
    .o_issue_cnt (issue_cnt)
  );

  always #5 rd_clk = ~rd_clk;

  // ---------------- FIFO models (read data one cycle after rd_en) ----------
  logic [DW-1:0] mem0 [64];
  logic [DW-1:0] mem1 [64];
  int wr0 = 0;
  int wr1 = 0;
  int rd0 = 0;
  int rd1 = 0;

  assign bus.ch0_rd_empty = (rd0 == wr0);
  assign bus.ch1_rd_empty = (rd1 == wr1);

  always @(negedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      rd0 <= wr0;
      rd1 <= wr1;
    end else begin
      if (bus.ch0_rd_en) begin
        bus.ch0_rd_data <= mem0[rd0[5:0]];
        rd0 <= rd0 + 1;
      end
      if (bus.ch1_rd_en) begin
        bus.ch1_rd_data <= mem1[rd1[5:0]];
        rd1 <= rd1 + 1;
      end
    end
  end

  // ---------------- bookkeeping ---------------------------------------------
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int p0       = 0;
  int p1       = 0;

  logic [DW-1:0] hs_data [64];
  logic          hs_src  [64];
  int            hs_cyc  [64];
  int            hs_n = 0;

  // Transaction-level model: after a decision in cycle N the popped entry
  // shows rd_en at N+1 and is presented from N+3 until accepted.
  bit            m_inflight = 1'b0;
  int            m_age      = 0;
  bit            m_grant    = 1'b0;
  bit            m_last     = 1'b1;
  logic [DW-1:0] m_data     = '0;
  logic [CW-1:0] m_cnt      = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_check();
    bit exp_rd0;
    bit exp_rd1;
    bit exp_v;
    bit e0;
    bit e1;
    bit g;
    e0 = bus.ch0_rd_empty;
    e1 = bus.ch1_rd_empty;
    if (rd_rst) begin
      m_inflight = 1'b0;
      m_last     = 1'b1;
      m_cnt      = '0;
      chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_rd_en", 64'({bus.ch1_rd_en, bus.ch0_rd_en}), 64'(0));
      chk("rst_issue_cnt", 64'(issue_cnt), 64'(0));
    end else begin
      exp_rd0 = m_inflight && (m_age == 1) && !m_grant;
      exp_rd1 = m_inflight && (m_age == 1) && m_grant;
      exp_v   = m_inflight && (m_age >= 3);
      chk("ch0_rd_en", 64'(bus.ch0_rd_en), 64'(exp_rd0));
      chk("ch1_rd_en", 64'(bus.ch1_rd_en), 64'(exp_rd1));
      chk("out_valid", 64'(bus.out_valid), 64'(exp_v));
      chk("busy", 64'(busy), 64'(m_inflight));
      chk("issue_cnt", 64'(issue_cnt), 64'(m_cnt));
      if (exp_v) begin
        chk("out_data", 64'(bus.out_data), 64'(m_data));
        chk("out_src", 64'(bus.out_src), 64'(m_grant));
      end
      if (bus.ch0_rd_en) p0++;
      if (bus.ch1_rd_en) p1++;
      if (bus.out_valid && bus.out_ready) begin
        hs_data[hs_n[5:0]] = bus.out_data;
        hs_src[hs_n[5:0]]  = bus.out_src;
        hs_cyc[hs_n[5:0]]  = cyc;
        hs_n++;
      end
      if (exp_v && bus.out_ready) begin
        m_cnt      = m_cnt + 1'b1;
        m_inflight = 1'b0;
      end else if (m_inflight) begin
        m_age++;
      end
      if (!m_inflight && arb_en && (!e0 || !e1)) begin
        if (!e0 && !e1) g = !m_last;
        else            g = e0;
        m_grant    = g;
        m_last     = g;
        m_inflight = 1'b1;
        m_age      = 1;
        m_data     = g ? mem1[rd1[5:0]] : mem0[rd0[5:0]];
      end
    end
    cyc++;
  endtask

  // Inputs change on the falling edge; the model samples 1 time unit before
  // the rising edge that closes the cycle.
  task automatic tick();
    #4;
    do_check();
    @(negedge rd_clk);
  endtask

  task automatic push0(input logic [DW-1:0] d);
    mem0[wr0[5:0]] = d;
    wr0++;
  endtask

  task automatic push1(input logic [DW-1:0] d);
    mem1[wr1[5:0]] = d;
    wr1++;
  endtask

  task automatic wait_valid(input string name, input int max_cycles);
    int n;
    n = 0;
    while (!bus.out_valid && n < max_cycles) begin
      tick();
      n++;
    end
    chk(name, 64'(bus.out_valid), 64'(1));
  endtask

  task automatic chk_hs(input string name, input int idx, input logic [DW-1:0] d, input logic s);
    int k;
    k = idx;
    chk({name, "_data"}, 64'(hs_data[k[5:0]]), 64'(d));
    chk({name, "_src"}, 64'(hs_src[k[5:0]]), 64'(s));
  endtask

  task automatic chk_gap(input string name, input int idx, input int gap);
    int a;
    int b;
    a = idx;
    b = idx + 1;
    chk(name, 64'(hs_cyc[b[5:0]] - hs_cyc[a[5:0]]), 64'(gap));
  endtask

  int base;
  int c0;
  int p0s;
  int p1s;
  int ka;

  initial begin
    bus.out_ready = 1'b0;
    @(negedge rd_clk);
    repeat (3) tick();

    // Reset values
    chk("reset_out_valid", 64'(bus.out_valid), 64'(0));
    chk("reset_out_data", 64'(bus.out_data), 64'(0));
    chk("reset_out_src", 64'(bus.out_src), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_issue_cnt", 64'(issue_cnt), 64'(0));
    chk("reset_rd_en", 64'({bus.ch1_rd_en, bus.ch0_rd_en}), 64'(0));

    rd_rst = 1'b0;
    arb_en = 1'b1;
    bus.out_ready = 1'b1;
    tick();

    // Single entry
    base = hs_n;
    p0s  = p0;
    c0   = cyc;
    push0(44'h0AB_CDEF_0123);
    repeat (8) tick();
    chk("single_count", 64'(hs_n - base), 64'(1));
    chk_hs("single", base, 44'h0AB_CDEF_0123, 1'b0);
    ka = base;
    chk("single_latency", 64'(hs_cyc[ka[5:0]] - c0), 64'(3));
    chk("single_pulses", 64'(p0 - p0s), 64'(1));
    chk("single_issue_cnt", 64'(issue_cnt), 64'(1));
    chk("single_busy", 64'(busy), 64'(0));

    // Asynchronous reset while an entry is presented
    bus.out_ready = 1'b0;
    push1(44'h0DE_AD00_BEEF);
    wait_valid("rstmid_wait_valid", 12);
    chk("rstmid_src_before", 64'(bus.out_src), 64'(1));
    rd_rst = 1'b1;
    #1;
    chk("rstmid_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rstmid_out_data", 64'(bus.out_data), 64'(0));
    chk("rstmid_out_src", 64'(bus.out_src), 64'(0));
    chk("rstmid_busy", 64'(busy), 64'(0));
    chk("rstmid_issue_cnt", 64'(issue_cnt), 64'(0));
    #3;
    do_check();
    @(negedge rd_clk);
    tick();
    rd_rst = 1'b0;
    bus.out_ready = 1'b1;
    tick();

    // Round-robin: first tie after reset goes to ch0
    base = hs_n;
    push0(44'h000_0000_00A0);
    push0(44'h000_0000_00A1);
    push1(44'h000_0000_00B0);
    push1(44'h000_0000_00B1);
    repeat (16) tick();
    chk("rr_count", 64'(hs_n - base), 64'(4));
    chk_hs("rr0", base,     44'h000_0000_00A0, 1'b0);
    chk_hs("rr1", base + 1, 44'h000_0000_00B0, 1'b1);
    chk_hs("rr2", base + 2, 44'h000_0000_00A1, 1'b0);
    chk_hs("rr3", base + 3, 44'h000_0000_00B1, 1'b1);
    for (int i = 0; i < 3; i++) chk_gap("rr_gap", base + i, 3);
    chk("rr_issue_cnt", 64'(issue_cnt), 64'(4));

    // Backpressure
    bus.out_ready = 1'b0;
    push0(44'h123_4567_89AB);
    push0(44'h0FE_DCBA_9876);
    wait_valid("bp_wait_valid", 12);
    p0s = p0;
    p1s = p1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold_valid", 64'(bus.out_valid), 64'(1));
      chk("bp_hold_data", 64'(bus.out_data), 64'(44'h123_4567_89AB));
    end
    chk("bp_no_pulses", 64'((p0 - p0s) + (p1 - p1s)), 64'(0));
    base = hs_n;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    repeat (3) tick();
    chk("bp_one_handshake", 64'(hs_n - base), 64'(1));
    chk_hs("bp", base, 44'h123_4567_89AB, 1'b0);
    wait_valid("bp_wait_second", 12);
    chk("bp_second_data", 64'(bus.out_data), 64'(44'h0FE_DCBA_9876));
    bus.out_ready = 1'b1;
    repeat (3) tick();

    // Empty guard: ch1 stays empty
    base = hs_n;
    p1s  = p1;
    push0(44'h000_0000_0E00);
    push0(44'h000_0000_0E01);
    push0(44'h000_0000_0E02);
    repeat (14) tick();
    chk("eg_count", 64'(hs_n - base), 64'(3));
    chk_hs("eg0", base,     44'h000_0000_0E00, 1'b0);
    chk_hs("eg1", base + 1, 44'h000_0000_0E01, 1'b0);
    chk_hs("eg2", base + 2, 44'h000_0000_0E02, 1'b0);
    chk("eg_ch1_pulses", 64'(p1 - p1s), 64'(0));

    // arb_en dropped during CAPT
    base = hs_n;
    p0s  = p0;
    push0(44'h000_0000_0F00);
    push0(44'h000_0000_0F01);
    tick();
    tick();
    arb_en = 1'b0;
    repeat (6) tick();
    chk("ae_first_only", 64'(hs_n - base), 64'(1));
    chk_hs("ae0", base, 44'h000_0000_0F00, 1'b0);
    chk("ae_pulses", 64'(p0 - p0s), 64'(1));
    chk("ae_idle_busy", 64'(busy), 64'(0));
    arb_en = 1'b1;
    repeat (6) tick();
    chk("ae_second", 64'(hs_n - base), 64'(2));
    chk_hs("ae1", base + 1, 44'h000_0000_0F01, 1'b0);
    chk("final_issue_cnt", 64'(issue_cnt), 64'(11));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/master_addr_fifo_arbiter.md
# master_addr_fifo_arbiter

Read-side scheduler for the AXI4 master's two asynchronous address FIFOs (write-address and read-address, 44-bit entries each). It runs in the rd_clk domain and pops entries from whichever FIFO is non-empty, using round-robin when both are ready. It presents one entry at a time on a single valid/ready output channel, tagged with its source, for the downstream AXI address issue logic.

## Interface
- DATA_WIDTH, 44, width of one FIFO entry and of out_data
- CNT_WIDTH, 16, width of issue_cnt
- rd_clk  in  1  clock; read clock shared with both FIFOs' read ports
- rd_rst  in  1  reset rd_rst, asynchronous, active-high
- arb_en  in  1  1 = new pops allowed; 0 = finish in-flight entry, then idle
- ch0_rd_en  out  1  pop strobe to FIFO 0 (write-address FIFO)
- ch0_rd_data  in  DATA_WIDTH  FIFO 0 read data, valid the cycle after ch0_rd_en
- ch0_rd_empty  in  1  FIFO 0 empty
- ch1_rd_en  out  1  pop strobe to FIFO 1 (read-address FIFO)
- ch1_rd_data  in  DATA_WIDTH  FIFO 1 read data, valid the cycle after ch1_rd_en
- ch1_rd_empty  in  1  FIFO 1 empty
- out_valid  out  1  out_data/out_src hold a valid entry
- out_ready  in  1  downstream accepts the entry when out_valid=1
- out_data  out  DATA_WIDTH  captured FIFO entry, unmodified
- out_src  out  1  0 = entry from ch0, 1 = entry from ch1
- busy  out  1  state != IDLE
- issue_cnt  out  CNT_WIDTH  count of completed output handshakes, wraps

## Operation
- FSM states: IDLE, READ, CAPT, VALID.
- IDLE: if arb_en=1 and at least one rd_empty=0, pick a grant and go to READ. Otherwise stay in IDLE.
- Grant rule: if only one channel is non-empty, grant it. If both are non-empty, grant the channel != last_grant. last_grant updates when the grant is made. last_grant resets to 1, so ch0 wins the first tie.
- READ lasts exactly one cycle. chN_rd_en = (state==READ && grant==N), combinational from registered state/grant. Next state is CAPT.
- CAPT lasts exactly one cycle. The granted channel's rd_data is valid this cycle. At the closing edge, out_data <= granted rd_data, out_src <= grant, out_valid <= 1. Next state is VALID.
- VALID: hold out_valid, out_data and out_src stable until out_valid && out_ready. On that edge:
  - issue_cnt += 1 (modulo 2^CNT_WIDTH) and out_valid <= 0.
  - If arb_en=1 and any channel is non-empty (sampled that cycle), make a new grant and go to READ. Otherwise go to IDLE.
- A channel whose rd_empty=1 at the decision cycle is never granted. rd_en is never asserted on an empty FIFO.
- arb_en is sampled only at decision points (IDLE, and the handshake edge in VALID). Deasserting it never aborts READ, CAPT or VALID.
- rd_data is not inspected or reformatted. Field decoding belongs downstream.

## Timing
- Reset values: state=IDLE, out_valid=0, out_data=0, out_src=0, ch0_rd_en=0, ch1_rd_en=0, busy=0, issue_cnt=0, last_grant=1.
- Latency: decision in cycle N (IDLE) → rd_en high in cycle N+1 → rd_data valid in N+2 → out_valid high from N+3.
- Back-to-back: handshake in cycle M with a pending entry → rd_en in M+1, out_valid in M+3. out_valid is low during M+1 and M+2. Peak throughput is 1 entry per 3 cycles.
- out_ready may be high before out_valid. It has no effect outside VALID.
- Reset mid-operation: an entry already popped (READ/CAPT/VALID) but not handshaken is discarded. This is permitted because the FIFO read side is reset together with rd_rst.
- Simultaneous events: the new grant at the handshake edge uses the same-cycle rd_empty. A FIFO going non-empty that cycle is seen.

## Test plan
- Reset: assert rd_rst mid-VALID with out_valid=1 → all outputs at reset values within the same cycle (asynchronous). After release, the first tie goes to ch0.
- Single entry: ch0 holds 0x0AB_CDEF_0123, out_ready=1 → ch0_rd_en pulses one cycle. Two cycles later out_valid=1, out_data=0x0AB_CDEF_0123, out_src=0. issue_cnt goes to 1, then the block returns to IDLE with busy=0.
- Round-robin: ch0 holds A0,A1 and ch1 holds B0,B1, out_ready=1 → output order A0,B0,A1,B1 with out_src 0,1,0,1, handshakes 3 cycles apart, issue_cnt=4.
- Backpressure: out_ready=0 for 10 cycles during VALID → out_valid and out_data are stable and no rd_en pulses. Raising out_ready completes exactly one handshake.
- Empty guard: ch1_rd_empty=1 for the whole run while ch0 supplies 3 entries → ch1_rd_en is never 1. Output src is 0,0,0.
- arb_en: deassert arb_en during CAPT with 2 entries in ch0 → the first entry is still delivered, then IDLE with no further rd_en. Re-asserting arb_en delivers the second entry.
